// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM encoding, default sizing and the digit-range helper.
package bcd_to_binary_seq_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 13;
  localparam int ITER_DEF   = 14;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] DABBLE_THRESH = 4'd8;
  localparam logic [3:0] DABBLE_CORR   = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_bad(input logic [3:0] digit);
    return (digit > BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_dabble_sub3.sv
// Reverse double-dabble correction cell: a nibble that received a shifted-in
// weight of 8 really carries 5, so take 3 back off.
module dabble_sub3
  import bcd_to_binary_seq_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] fixed
);

  assign fixed = (nib >= DABBLE_THRESH) ? (nib - DABBLE_CORR) : nib;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Iterative packed-BCD to binary converter: one right shift plus per-digit
// subtract-3 correction per clock, with digit validation and saturation.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF,
  parameter int ITER   = ITER_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  ovf,
  output logic                  err
);

  localparam int R_W   = 4*DIGITS + ITER;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [ITER-1:0]  BIN_MAX  = {{(ITER-BIN_W){1'b0}}, {BIN_W{1'b1}}};

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [R_W-1:0]        r_r, r_nxt_s;
  logic                  bad_r, bad_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  done_r, done_nxt_s;
  logic [BIN_W-1:0]      bin_out_r, bin_nxt_s;
  logic                  ovf_r, ovf_nxt_s;
  logic                  err_r, err_nxt_s;

  logic [R_W-1:0]        r_shift_s;
  logic [4*DIGITS-1:0]   nib_fix_s;
  logic [R_W-1:0]        r_iter_s;
  logic [ITER-1:0]       v_s;
  logic                  any_bad_s;

  assign r_shift_s = r_r >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
    dabble_sub3 u_sub3 (
      .nib   (r_shift_s[ITER + 4*g +: 4]),
      .fixed (nib_fix_s[4*g +: 4])
    );
  end

  assign r_iter_s = {nib_fix_s, r_shift_s[ITER-1:0]};
  assign v_s      = r_iter_s[ITER-1:0];

  // Flag any input digit outside 0..9
  always_comb begin
    any_bad_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      any_bad_s = any_bad_s | digit_bad(bcd_in[4*i +: 4]);
    end
  end

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    r_nxt_s     = r_r;
    bad_nxt_s   = bad_r;
    bin_nxt_s   = bin_out_r;
    ovf_nxt_s   = ovf_r;
    err_nxt_s   = err_r;
    case (state_r)
      // DONE also accepts a new request so back-to-back runs take ITER+1 cycles
      IDLE, DONE: begin
        if (start) begin
          cnt_nxt_s   = '0;
          state_nxt_s = CONV;
          if (any_bad_s) begin
            // invalid input idles one cycle in CONV so done lands one edge later
            bad_nxt_s = 1'b1;
            err_nxt_s = 1'b1;
            ovf_nxt_s = 1'b0;
            bin_nxt_s = '0;
          end else begin
            bad_nxt_s = 1'b0;
            err_nxt_s = 1'b0;
            ovf_nxt_s = 1'b0;
            r_nxt_s   = {bcd_in, {ITER{1'b0}}};
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONV: begin
        if (bad_r) begin
          bad_nxt_s   = 1'b0;
          state_nxt_s = DONE;
        end else begin
          r_nxt_s   = r_iter_s;
          cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = DONE;
            if (v_s > BIN_MAX) begin
              bin_nxt_s = {BIN_W{1'b1}};
              ovf_nxt_s = 1'b1;
            end else begin
              bin_nxt_s = v_s[BIN_W-1:0];
              ovf_nxt_s = 1'b0;
            end
          end else begin
            state_nxt_s = CONV;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      r_r       <= '0;
      bad_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bin_out_r <= '0;
      ovf_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      r_r       <= r_nxt_s;
      bad_r     <= bad_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      bin_out_r <= bin_nxt_s;
      ovf_r     <= ovf_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bin_out = bin_out_r;
  assign ovf     = ovf_r;
  assign err     = err_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed table, handshake and
// reset corner sequences, and a random sweep against a decimal model.
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [12:0] bin_out;
  logic        ovf;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bcd_to_binary_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .ovf     (ovf),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [12:0] bin;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string tag, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s/%s: got %0d, expected %0d", tag, nm, act, exp);
  endtask

  // Decimal reference: weigh the digits, then validate and saturate
  function automatic void ref_model(input logic [15:0] bcd, output logic [12:0] b,
                                    output logic o, output logic e);
    int val;
    int d;
    e   = 1'b0;
    val = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'((bcd >> (4*i)) & 16'hF);
      if (d > 9) e = 1'b1;
      val = val * 10 + d;
    end
    if (e) begin
      b = 13'd0; o = 1'b0;
    end else if (val > 8191) begin
      b = 13'h1FFF; o = 1'b1;
    end else begin
      b = val[12:0]; o = 1'b0;
    end
  endfunction

  // One full request: start, wait for done, check result, latency and return to idle
  task automatic run_conv(input logic [15:0] bcd, input logic [12:0] eb,
                          input logic eo, input logic ee, input string tag);
    int lat;
    bit seen;
    int exp_lat;
    exp_lat = ee ? 1 : 14;
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'($urandom);
    check(tag, "busy_after_start", busy, 1);
    seen = 0;
    lat  = 0;
    if (done) begin seen = 1; lat = 0; end
    for (int k = 1; k <= 40; k++) begin
      if (!seen) begin
        @(posedge clk);
        @(negedge clk);
        bcd_in = 16'($urandom);
        if (done) begin seen = 1; lat = k; end
      end
    end
    check(tag, "done_seen", seen, 1);
    check(tag, "latency", lat, exp_lat);
    check(tag, "bin_out", bin_out, eb);
    check(tag, "ovf", ovf, eo);
    check(tag, "err", err, ee);
    @(posedge clk);
    @(negedge clk);
    check(tag, "busy_idle", busy, 0);
    check(tag, "done_pulse", done, 0);
  endtask

  initial begin
    logic [12:0] eb;
    logic        eo, ee;
    logic [15:0] rv;
    int          dq[$];
    int          done_cnt;
    bit          seen;
    int          lat;

    vecs[0] = '{16'h8191, 13'd8191, 1'b0, 1'b0};
    vecs[1] = '{16'h8192, 13'd8191, 1'b1, 1'b0};
    vecs[2] = '{16'h9999, 13'd8191, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 13'd0,    1'b0, 1'b0};
    vecs[4] = '{16'h0009, 13'd9,    1'b0, 1'b0};
    vecs[5] = '{16'h0010, 13'd10,   1'b0, 1'b0};
    vecs[6] = '{16'h1000, 13'd1000, 1'b0, 1'b0};
    vecs[7] = '{16'h00A5, 13'd0,    1'b0, 1'b1};
    vecs[8] = '{16'h0537, 13'd537,  1'b0, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    #12;
    check("reset", "busy", busy, 0);
    check("reset", "done", done, 0);
    check("reset", "bin_out", bin_out, 0);
    check("reset", "ovf", ovf, 0);
    check("reset", "err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].bcd, vecs[i].bin, vecs[i].ovf, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Continuous start: one result every 15 cycles
    @(negedge clk);
    bcd_in = 16'h0123;
    start  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dq.push_back(c);
    end
    start = 1'b0;
    check("cont", "n_done", (dq.size() >= 3) ? 1 : 0, 1);
    check("cont", "first_done", (dq.size() > 0) ? dq[0] : -1, 14);
    check("cont", "period1", (dq.size() > 1) ? dq[1] - dq[0] : -1, 15);
    check("cont", "period2", (dq.size() > 2) ? dq[2] - dq[1] : -1, 15);
    check("cont", "bin_out", bin_out, 123);
    repeat (20) @(negedge clk);

    // Start pulses and bcd_in changes during CONV are ignored
    @(negedge clk);
    bcd_in = 16'h0777;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    lat   = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!seen) begin
        @(posedge clk);
        @(negedge clk);
        start  = (k == 3 || k == 13) ? 1'b1 : 1'b0;
        bcd_in = (k == 3 || k == 13) ? 16'h0555 : 16'($urandom);
        if (done) begin seen = 1; lat = k; end
      end
    end
    start = 1'b0;
    check("ignore", "latency", lat, 14);
    check("ignore", "bin_out", bin_out, 777);
    @(posedge clk);
    @(negedge clk);
    check("ignore", "busy_idle", busy, 0);
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("ignore", "no_second_run", bin_out, 777);

    // Reset mid-conversion aborts with no done pulse
    @(negedge clk);
    bcd_in = 16'h1234;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst", "busy", busy, 0);
    check("midrst", "done", done, 0);
    check("midrst", "bin_out", bin_out, 0);
    check("midrst", "ovf", ovf, 0);
    check("midrst", "err", err, 0);
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst", "no_done", done_cnt, 0);
    run_conv(16'h0042, 13'd42, 1'b0, 1'b0, "after_rst");

    // Random sweep over valid BCD values
    for (int n = 0; n < 1000; n++) begin
      rv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ref_model(rv, eb, eo, ee);
      run_conv(rv, eb, eo, ee, $sformatf("rnd_%04h", rv));
    end
    // Arbitrary nibbles, including invalid digits
    for (int n = 0; n < 100; n++) begin
      rv = 16'($urandom);
      ref_model(rv, eb, eo, ee);
      run_conv(rv, eb, eo, ee, $sformatf("any_%04h", rv));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
